// File: rtl/therm_decode.sv
// Thermometer-code LED bus tracker: decodes fill level, counts samples, flags illegal codes.
// Optional THERM_DECODE_MONO_CHECK_EN: reject legal codes that jump away from previous level.
module therm_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] led_in,
  output logic [4:0]  level,
  output logic [7:0]  cycles,
  output logic        valid,
  output logic        full,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_e;

  state_e      state_q;
  logic [4:0]  level_q;
  logic [7:0]  cycles_q;
  logic [7:0]  cycles_d;
  logic        valid_q;
  logic        full_q;
  logic        err_q;
  logic        code_legal;
  logic [4:0]  code_k;
  logic        accept;

  // A thermometer code has no set bit above a clear bit, so x & (x+1) is zero.
  always_comb begin
    code_legal = ((led_in & (led_in + 16'd1)) == '0);
    code_k     = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      code_k = code_k + {4'd0, led_in[i]};
    end
  end

  assign cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + 8'd1;

`ifdef THERM_DECODE_MONO_CHECK_EN
  logic [4:0] prev_q;
  assign accept = code_legal && ((code_k == prev_q) || (code_k == prev_q + 5'd1));
`else
  assign accept = code_legal;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      level_q  <= '0;
      cycles_q <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef THERM_DECODE_MONO_CHECK_EN
      prev_q   <= '0;
`endif
    end else begin
      case (state_q)
        TRACK: begin
          cycles_q <= cycles_d;
          if (accept) begin
            level_q <= code_k;
            valid_q <= 1'b1;
`ifdef THERM_DECODE_MONO_CHECK_EN
            prev_q  <= code_k;
`endif
            if (code_k == 5'd16) begin
              full_q  <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            err_q   <= 1'b1;
            state_q <= ERR;
          end
        end
        default: begin
          if (start) begin
            state_q  <= TRACK;
            level_q  <= '0;
            cycles_q <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef THERM_DECODE_MONO_CHECK_EN
            prev_q   <= '0;
`endif
          end
        end
      endcase
    end
  end

  assign level  = level_q;
  assign cycles = cycles_q;
  assign valid  = valid_q;
  assign full   = full_q;
  assign err    = err_q;
  assign busy   = (state_q == TRACK);

endmodule
